// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default sizing.
package clk_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a history flop that
// turns the synchronized level into one-cycle rise and fall pulses.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic hist_q;

    // Synchronizer chain and previous-level history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign rise = s2_q & ~hist_q;
    assign fall = ~s2_q & hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow asynchronous clock in units of
// the system clock, with a timeout for a stalled input and a valid/ready result.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned          CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0]     TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic rise_s;
    logic fall_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             tmo_q, tmo_d;
    logic             high_seen_q, high_seen_d;
    logic             busy_q;
    logic             valid_q;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (div_in),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Next-state, counter and result capture; a closing rise beats a timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        high_d      = high_q;
        tmo_d       = tmo_q;
        high_seen_d = high_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WAIT_EDGE;
                    cnt_d       = '0;
                    tmo_d       = 1'b0;
                    high_seen_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_EDGE: begin
                if (rise_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = ONE;
                end else if (cnt_q == TIMEOUT) begin
                    state_d  = ST_DONE;
                    tmo_d    = 1'b1;
                    period_d = ALL_ONES;
                    high_d   = ALL_ONES;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_MEASURE: begin
                if (rise_s) begin
                    state_d  = ST_DONE;
                    period_d = cnt_q;
                    tmo_d    = 1'b0;
                end else begin
                    if (fall_s) begin
                        high_d      = cnt_q;
                        high_seen_d = 1'b1;
                    end else begin
                        high_seen_d = high_seen_q;
                    end
                    if (cnt_q == TIMEOUT) begin
                        state_d  = ST_DONE;
                        tmo_d    = 1'b1;
                        period_d = ALL_ONES;
                        if (!high_seen_q && !fall_s) begin
                            high_d = ALL_ONES;
                        end else begin
                            high_d = high_d;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            ST_DONE: begin
                if (ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, result and status registers; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            high_q      <= '0;
            tmo_q       <= 1'b0;
            high_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            tmo_q       <= tmo_d;
            high_seen_q <= high_seen_d;
            busy_q      <= (state_d == ST_WAIT_EDGE) || (state_d == ST_MEASURE);
            valid_q     <= (state_d == ST_DONE);
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign period_out = period_q;
    assign high_out   = high_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes the expected result,
// a monitor compares whenever the DUT presents one.
module tb_clk_period_meter;

    localparam int unsigned W = 16;
    localparam logic [W-1:0] ONES = 16'hFFFF;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic         t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         div_in = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b1;
    logic         busy;
    logic         valid;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         timeout;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    // periodic div_in generator
    logic gen_mode = 1'b0;
    int   gen_p = 2;
    int   gen_h = 1;
    int   gen_ph = 0;

    clk_period_meter #(.CNT_W(W), .TIMEOUT(16'd100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_in     (div_in),
        .start      (start),
        .busy       (busy),
        .valid      (valid),
        .ready      (ready),
        .period_out (period_out),
        .high_out   (high_out),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (gen_mode) begin
            div_in = (gen_ph < gen_h);
            gen_ph = (gen_ph + 1 >= gen_p) ? 0 : gen_ph + 1;
        end
    end

    // monitor: compare every presented result against the queue head
    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got valid=1 with p=%0d h=%0d t=%0b, required no result",
                         period_out, high_out, timeout);
            end else begin
                cur = sb[0];
                if (period_out !== cur.p || high_out !== cur.h || timeout !== cur.t) begin
                    n_bad++;
                    $display("FAIL result: got p=%0d h=%0d t=%0b, required p=%0d h=%0d t=%0b",
                             period_out, high_out, timeout, cur.p, cur.h, cur.t);
                end
                if (ready) void'(sb.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(input int p, input int h, input logic t);
        exp_t e;
        e.p = W'(p);
        e.h = W'(h);
        e.t = t;
        sb.push_back(e);
    endtask

    // wait for the scoreboard to drain, then check the return to idle
    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait: got %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk({name, "_valid_drop"}, {31'd0, valid}, 32'd0);
        chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
        step();
    endtask

    task automatic run_periodic(input string name, input int p, input int h);
        gen_p = p;
        gen_h = h;
        gen_ph = 0;
        gen_mode = 1'b1;
        repeat ($urandom_range(p + 2, 1)) step();
        push(p, h, 1'b0);
        pulse_start();
        wait_done(name);
    endtask

    initial begin
        int p;
        int h;
        // reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_period", {16'd0, period_out}, 32'd0);
        chk("rst_high", {16'd0, high_out}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // divide-by-2 and 10/3 patterns
        run_periodic("div2", 2, 1);
        run_periodic("p10h3", 10, 3);

        // busy during measurement
        gen_mode = 1'b0;
        div_in = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("busy_wait", {31'd0, busy}, 32'd1);

        // timeout in WAIT_EDGE with div_in stuck low
        push(ONES, ONES, 1'b1);
        for (int i = 0; i < 300 && !valid; i++) @(negedge clk);
        chk("tmo_wait_valid", {31'd0, valid}, 32'd1);
        wait_done("tmo_wait");

        // timeout in MEASURE after the high phase was latched
        div_in = 1'b0;
        pulse_start();
        repeat (3) step();
        div_in = 1'b1;
        repeat (30) step();
        div_in = 1'b0;
        push(ONES, 30, 1'b1);
        wait_done("tmo_meas_hi");

        // timeout in MEASURE with no fall at all
        pulse_start();
        repeat (3) step();
        div_in = 1'b1;
        push(ONES, ONES, 1'b1);
        wait_done("tmo_meas_nohi");

        // result held with ready low for 50 cycles
        ready = 1'b0;
        gen_p = 10;
        gen_h = 3;
        gen_ph = 0;
        gen_mode = 1'b1;
        repeat (4) step();
        push(10, 3, 1'b0);
        pulse_start();
        for (int i = 0; i < 500 && !valid; i++) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, valid}, 32'd1);
        end
        step();
        ready = 1'b1;
        wait_done("hold");

        // second start during MEASURE is ignored
        gen_mode = 1'b0;
        div_in = 1'b0;
        step();
        pulse_start();
        repeat (3) step();
        div_in = 1'b1;
        repeat (4) step();
        div_in = 1'b0;
        push(10, 4, 1'b0);
        pulse_start();
        repeat (5) step();
        div_in = 1'b1;
        wait_done("restart_ign");

        // reset mid-MEASURE aborts with no result
        div_in = 1'b0;
        step();
        pulse_start();
        repeat (3) step();
        div_in = 1'b1;
        repeat (10) step();
        div_in = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_period", {16'd0, period_out}, 32'd0);
        chk("mrst_high", {16'd0, high_out}, 32'd0);
        step();
        rst_n = 1'b1;
        div_in = 1'b1;
        repeat (40) step();
        div_in = 1'b0;
        repeat (40) step();
        run_periodic("after_rst", 12, 5);

        // randomized periods and duty cycles
        for (int k = 0; k < 10; k++) begin
            p = $urandom_range(40, 2);
            h = $urandom_range(p - 1, 1);
            run_periodic("rand", p, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the cycle counter and the result outputs.
REQ-002 Parameter TIMEOUT, default 16'hFFFF: maximum cycles to wait for an edge before aborting; must satisfy 4 <= TIMEOUT < 2^CNT_W.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 div_in  input  1  asynchronous slow clock or divided clock under measurement.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 busy  output  1  high while a measurement is in progress.
REQ-008 valid  output  1  high while a result is held.
REQ-009 ready  input  1  consumer accepts the result on valid && ready.
REQ-010 period_out  output  CNT_W  clk cycles between two consecutive div_in rising edges.
REQ-011 high_out  output  CNT_W  clk cycles div_in spent high within that period.
REQ-012 timeout  output  1  the held result is an aborted measurement.

Function
REQ-013 div_in shall pass through a 2-flop synchronizer plus one history flop; rise/fall pulses are 1 cycle wide and appear 3 clk cycles after the pin transition.
REQ-014 The FSM shall have exactly four states: IDLE, WAIT_EDGE, MEASURE and DONE.
REQ-015 IDLE: start=1 -> WAIT_EDGE, counter cleared to 0; start is ignored in every other state.
REQ-016 WAIT_EDGE: counter increments each cycle; rise pulse -> MEASURE with counter loaded to 1.
REQ-017 MEASURE: counter increments each cycle; fall pulse latches high_out = counter; next rise pulse latches period_out = counter and moves to DONE.
REQ-018 Counting rule: a rise at cycle t0 and the next rise at t0+N shall yield period_out = N; a fall at t0+H shall yield high_out = H.
REQ-019 Timeout: if the counter equals TIMEOUT in WAIT_EDGE or MEASURE, the FSM shall go to DONE with timeout=1, period_out all-ones, and high_out unchanged if already latched or all-ones otherwise.
REQ-020 A rise and a counter==TIMEOUT condition in the same cycle shall resolve as a normal completion, with timeout=0.
REQ-021 DONE: valid=1; period_out, high_out and timeout stay stable until valid && ready, then the FSM returns to IDLE on the next cycle.
REQ-022 ready is a don't-care outside DONE; valid shall never assert combinationally from ready.
REQ-023 busy shall be 1 exactly in WAIT_EDGE and MEASURE.
REQ-024 Result latency: valid rises on the cycle after the closing rise pulse.
REQ-025 The counter shall never wrap; it is bounded by TIMEOUT.

Reset
REQ-026 While rst_n=0 at posedge clk, the state shall be IDLE, and valid, busy, timeout, period_out, high_out, the counter and all synchronizer flops shall be 0.
REQ-027 Reset mid-measurement shall abort without producing a result; the first start after release shall begin a fresh measurement.

Structure
REQ-028 The FSM state encoding, the default CNT_W and the default TIMEOUT shall live in the shared project package.
REQ-029 The synchronizer and edge detector shall be a sub-module named sync_edge_det, with ports clk, rst_n, d, rise, fall; all remaining logic stays in clk_period_meter.

Verification
REQ-030 div_in driven by the project divide-by-2 clock, start pulse, ready=1 -> valid for 1 cycle with period_out=2, high_out=1, timeout=0.
REQ-031 div_in period 10 cycles, high 3 cycles, start, ready=1 -> period_out=10, high_out=3.
REQ-032 TIMEOUT=100, div_in held 0, start -> valid after about 100 cycles with timeout=1 and period_out all-ones; then ready=1 -> IDLE.
REQ-033 period 10 result with ready held 0 for 50 cycles -> valid and outputs stable throughout; ready=1 -> valid falls the next cycle and busy=0.
REQ-034 start pulsed again during MEASURE -> ignored, result equals an uninterrupted run; rst_n=0 mid-MEASURE -> all outputs 0 and no valid until a new start.
